mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory load/store interface.
- Sits in the MEM pipeline stage. Accepts one load or store per instruction from the pipeline and drives a request/acknowledge port toward the word-addressed data memory.
- Stalls the pipeline until the memory acknowledges, then returns load data.
- Supports zero-wait and multi-cycle memories.

Parameters:
- ADDR_W, 8, word-address width presented to memory (256 words).
- TIMEOUT, 16, max cycles in REQ waiting for mem_ack (only used with MAU_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  MEM-stage instruction valid.
- req_read  input  1  instruction is a load.
- req_write  input  1  instruction is a store.
- req_addr  input  32  ALU result, word index; bits above ADDR_W ignored.
- req_wdata  input  32  store data (Reg2).
- stall  output  1  hold pipeline; combinational.
- load_data  output  32  registered load result.
- load_valid  output  1  one-cycle pulse when load_data updated by a read.
- err  output  1  one-cycle timeout pulse; constant 0 without MAU_TIMEOUT_EN.
- mem_req  output  1  registered request to memory.
- mem_we  output  1  registered; 1 = write, 0 = read.
- mem_addr  output  ADDR_W  registered word address.
- mem_wdata  output  32  registered write data.
- mem_ack  input  1  memory completion; sampled on clk.
- mem_rdata  input  32  read data, valid when mem_ack=1 and mem_we=0.

Behaviour:
- Reset: clk and reset naming fixed; reset is asynchronous and active-high. On reset assertion:
  - state=IDLE;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - load_data=0, load_valid=0, err=0.
  - Reset asserted mid-transaction drops mem_req immediately; the transaction is abandoned with no completion.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If req_valid && (req_read || req_write): latch mem_addr=req_addr[ADDR_W-1:0], mem_wdata=req_wdata, and mem_we=req_write (write wins if both set). Set mem_req=1 and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On a cycle with mem_ack=1: clear mem_req and go to DONE.
  - If the access is a read, capture load_data=mem_rdata on that edge.
  - mem_ack may be high in the first REQ cycle (zero-wait memory).
- DONE:
  - load_valid=1 for this cycle only, reads only.
  - req_* inputs are ignored; they belong to the instruction now advancing.
  - Return to IDLE next cycle.
- stall = (state==REQ) || (state==IDLE && req_valid && (req_read||req_write)). It is low in DONE.
- Latency: with a zero-wait memory, stall is high for 2 cycles (accept cycle + REQ cycle) and the instruction advances in the DONE cycle. Each wait state adds one stall cycle.
- load_data holds its last value until the next completed read. Stores never modify it.
- mem_ack outside REQ is ignored.
- req_valid=1 with neither read nor write is a no-op: no stall, stays in IDLE.
- Address wrap: req_addr=32'h0000_0105 with ADDR_W=8 produces mem_addr=8'h05.

Optional Feature:
- Macro MAU_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When it reaches TIMEOUT-1 with mem_ack still low: clear mem_req, go to DONE, pulse err for the DONE cycle, set load_data=32'h0, and keep load_valid=0.
  - mem_ack in the same cycle as expiry takes priority: normal completion, no err.
- Not defined: REQ waits indefinitely; no counter is built; err is tied to 0.

Test Plan:
- Zero-wait store, req_addr=0x10, req_wdata=0xCAFEF00D, mem_ack=1 in the first REQ cycle → mem_req/mem_we=1 for 1 cycle with mem_addr=0x10 and mem_wdata=0xCAFEF00D; stall high exactly 2 cycles; load_valid never asserts.
- Read with 3 wait states, mem_rdata=0x12345678 on ack → stall high 5 cycles; load_data=0x12345678 with load_valid pulse in DONE; addr/we stable throughout REQ.
- Back-to-back load then store on consecutive instructions → second accepted in the IDLE cycle after DONE; req_* present during DONE is ignored; load_data is unchanged by the store.
- Address truncation and no-op: req_addr=0x1FF read → mem_addr=0xFF. req_valid=1 with read=write=0 → stall=0, mem_req stays 0.
- Reset asserted while in REQ with mem_ack=0 → mem_req and stall go to 0 without waiting for clk; after release the FSM is in IDLE and load_data=0.
- With MAU_TIMEOUT_EN, TIMEOUT=16, mem_ack held 0 → mem_req drops after 16 REQ cycles, err pulses 1 cycle, load_data=0, stall releases. Without the macro → still stalled after 100 cycles, err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-addressed data memory: one load/store per instruction, stalls until mem_ack.
// Optional wait-state timeout is compiled in with `define MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                load_valid_q, load_valid_d;
  logic                accept;
  logic                expire;
  logic                unused_ok;

  assign accept    = (state_q == IDLE) && req_valid && (req_read || req_write);
  assign unused_ok = &{1'b0, req_addr[31:ADDR_W], TIMEOUT[0]};

`ifdef MAU_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  assign expire = (state_q == REQ) && !mem_ack && (wait_cnt_q == 8'(TIMEOUT - 1));
  assign err    = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
`ifdef MAU_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields only change on accept, so they stay stable for the whole REQ phase.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    stall        = (state_q == REQ) || accept;
`ifdef MAU_TIMEOUT_EN
    err_d        = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = '0;
    end else if ((state_q == REQ) && !mem_ack) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_req_d   = 1'b1;
          mem_we_d    = req_write;
          mem_addr_d  = req_addr[ADDR_W-1:0];
          mem_wdata_d = req_wdata;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            load_data_d  = mem_rdata;
            load_valid_d = 1'b1;
          end
        end else if (expire) begin
          mem_req_d   = 1'b0;
          load_data_d = '0;
`ifdef MAU_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_access_unit;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, load_valid, err, mem_req, mem_we;
  logic [31:0] load_data, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: an outstanding access, then one retire cycle in which it completes.
  bit          m_busy = 1'b0, m_retire = 1'b0, m_we = 1'b0, m_lv = 1'b0, m_err = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_wdata = '0, m_ld = '0;
  int          m_wait = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_retire <= 0; m_we <= 0; m_lv <= 0; m_err <= 0;
      m_addr <= '0; m_wdata <= '0; m_ld <= '0; m_wait <= 0;
    end else begin
      m_lv  <= 0;
      m_err <= 0;
      if (m_retire) begin
        m_retire <= 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy <= 0; m_retire <= 1;
          if (!m_we) begin
            m_ld <= mem_rdata; m_lv <= 1;
          end
        end else begin
          m_wait <= m_wait + 1;
`ifdef MAU_TIMEOUT_EN
          if (m_wait + 1 == TIMEOUT) begin
            m_busy <= 0; m_retire <= 1; m_err <= 1; m_ld <= '0;
          end
`endif
        end
      end else if (req_valid && (req_read || req_write)) begin
        m_busy <= 1; m_we <= req_write; m_addr <= req_addr[7:0];
        m_wdata <= req_wdata; m_wait <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      checkOutput("stall", {31'b0, stall},
                  {31'b0, m_busy || (!m_retire && req_valid && (req_read || req_write))});
      checkOutput("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
      checkOutput("load_valid", {31'b0, load_valid}, {31'b0, m_lv});
      checkOutput("err", {31'b0, err}, {31'b0, m_err});
      checkOutput("load_data", load_data, m_ld);
      if (m_busy) begin
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        checkOutput("mem_addr", {24'b0, mem_addr}, {24'b0, m_addr});
        checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // Memory responder: acks after ws wait states; stray drives ack while no request is open.
  int ws = 0;
  bit stray = 1'b0;
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mem_ack = (wcnt == ws);
      wcnt++;
    end else begin
      wcnt = 0;
      mem_ack = stray;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
  endtask

  int          n_stall, n_req;
  bit          stable;
  logic [7:0]  r_addr;
  logic        r_we, r_lv, r_err;
  logic [31:0] r_wdata, r_ld;

  task automatic waitStall(input int budget);
    n_stall = 0; n_req = 0; stable = 1; r_addr = '0; r_we = 0; r_wdata = '0;
    r_lv = 0; r_ld = '0; r_err = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n_req > 0 && (mem_addr !== r_addr || mem_we !== r_we || mem_wdata !== r_wdata))
          stable = 0;
        r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
        n_req++;
      end
      if (stall) n_stall++;
      else begin
        r_lv = load_valid; r_ld = load_data; r_err = err;
        return;
      end
    end
    checkOutput("stall_budget", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    checkOutput("rst_load_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    started = 1'b1;

    $display("[TB] zero-wait store");
    ws = 0;
    nextCycle();
    applyStimulus(1, 0, 1, 32'h10, 32'hCAFEF00D);
    waitStall(50);
    checkOutput("st_stall_cycles", n_stall, 2);
    checkOutput("st_req_cycles", n_req, 1);
    checkOutput("st_addr", {24'b0, r_addr}, 32'h10);
    checkOutput("st_we", {31'b0, r_we}, 32'd1);
    checkOutput("st_wdata", r_wdata, 32'hCAFEF00D);
    checkOutput("st_lv", {31'b0, r_lv}, 32'd0);

    $display("[TB] read with 3 wait states");
    ws = 3; mem_rdata = 32'h12345678;
    nextCycle();
    applyStimulus(1, 1, 0, 32'h44, 32'h0);
    waitStall(50);
    checkOutput("rd_stall_cycles", n_stall, 5);
    checkOutput("rd_req_cycles", n_req, 4);
    checkOutput("rd_stable", {31'b0, stable}, 32'd1);
    checkOutput("rd_addr", {24'b0, r_addr}, 32'h44);
    checkOutput("rd_we", {31'b0, r_we}, 32'd0);
    checkOutput("rd_lv", {31'b0, r_lv}, 32'd1);
    checkOutput("rd_data", r_ld, 32'h12345678);

    $display("[TB] back-to-back load then store");
    ws = 1; mem_rdata = 32'hA5A50001;
    nextCycle();
    applyStimulus(1, 1, 0, 32'h20, 32'h0);
    waitStall(50);
    checkOutput("b2b_ld_stall", n_stall, 3);
    checkOutput("b2b_ld_data", r_ld, 32'hA5A50001);
    ws = 0; mem_rdata = 32'hFFFF_FFFF;
    nextCycle();
    applyStimulus(1, 0, 1, 32'h21, 32'hDEADBEEF);
    waitStall(50);
    checkOutput("b2b_st_stall", n_stall, 2);
    checkOutput("b2b_st_addr", {24'b0, r_addr}, 32'h21);
    checkOutput("b2b_st_ld_kept", r_ld, 32'hA5A50001);
    checkOutput("b2b_st_lv", {31'b0, r_lv}, 32'd0);

    $display("[TB] address truncation and no-op");
    ws = 0; mem_rdata = 32'h0BADF00D;
    nextCycle();
    applyStimulus(1, 1, 0, 32'h1FF, 32'h0);
    waitStall(50);
    checkOutput("trunc_addr_ff", {24'b0, r_addr}, 32'hFF);
    checkOutput("trunc_data", r_ld, 32'h0BADF00D);
    ws = 2;
    nextCycle();
    applyStimulus(1, 0, 1, 32'h105, 32'h55AA55AA);
    waitStall(50);
    checkOutput("wrap_addr_05", {24'b0, r_addr}, 32'h05);
    checkOutput("wrap_stall", n_stall, 4);
    stray = 1;
    nextCycle();
    applyStimulus(1, 0, 0, 32'h7, 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noop_stall", {31'b0, stall}, 32'd0);
      checkOutput("noop_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("noop_lv", {31'b0, load_valid}, 32'd0);
    end
    stray = 0;
    checkOutput("noop_ld_kept", load_data, 32'h0BADF00D);

    $display("[TB] reset during REQ");
    ws = 1000;
    nextCycle();
    applyStimulus(1, 1, 0, 32'h33, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("async_rst_stall", {31'b0, stall}, 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_load_data", load_data, 32'd0);
    ws = 0;
    nextCycle();
    applyStimulus(1, 0, 1, 32'h3, 32'h3);
    waitStall(50);
    checkOutput("post_rst_idle_stall", n_stall, 2);

    $display("[TB] no-ack behaviour");
    ws = 1000;
    nextCycle();
    applyStimulus(1, 1, 0, 32'h50, 32'h0);
`ifdef MAU_TIMEOUT_EN
    waitStall(100);
    checkOutput("to_stall_cycles", n_stall, TIMEOUT + 1);
    checkOutput("to_req_cycles", n_req, TIMEOUT);
    checkOutput("to_err", {31'b0, r_err}, 32'd1);
    checkOutput("to_load_data", r_ld, 32'd0);
    checkOutput("to_lv", {31'b0, r_lv}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
`else
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (err) checkOutput("hang_err", {31'b0, err}, 32'd0);
    end
    checkOutput("hang_stall_cycles", n_stall, 100);
    checkOutput("hang_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("hang_err_final", {31'b0, err}, 32'd0);
    #2;
    reset = 1'b1;
    req_valid = 1'b0;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
`endif

    nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
